// File: rtl/fft_butterfly_pipe.sv
`default_nettype none
// =============================================================================
// Module   : fft_butterfly_pipe
// Brief    : Radix-2 butterfly, 3 register stages: x = A + B*W, y = A - B*W,
//            with a Q1.14 twiddle W. Define FFT_BFLY_SCALE_EN to halve the
//            stage-3 results (floor) instead of saturating them.
// Revision : 1.0  initial release
// =============================================================================
module fft_butterfly_pipe (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [15:0] a_re,
    input  logic signed [15:0] a_im,
    input  logic signed [15:0] b_re,
    input  logic signed [15:0] b_im,
    input  logic signed [15:0] w_re,
    input  logic signed [15:0] w_im,
    input  logic               clr_ovf,
    output logic               out_valid,
    output logic signed [15:0] x_re,
    output logic signed [15:0] x_im,
    output logic signed [15:0] y_re,
    output logic signed [15:0] y_im,
    output logic               ovf
);

    localparam logic signed [32:0] c_ROUND = 33'sd8192;

    // Returns {clipped, value} for a 19-bit signed input clamped to 16 bits.
    function automatic logic [16:0] sat16(input logic signed [18:0] v);
        if (v > 19'sd32767)
            return {1'b1, 16'h7fff};
        else if (v < -19'sd32768)
            return {1'b1, 16'h8000};
        else
            return {1'b0, v[15:0]};
    endfunction

    logic                      v1_q, v1_d, v2_q, v2_d;
    logic signed [15:0]        a_re1_q, a_re1_d, a_im1_q, a_im1_d;
    logic signed [31:0]        prod_rr_q, prod_rr_d, prod_ii_q, prod_ii_d;
    logic signed [31:0]        prod_ri_q, prod_ri_d, prod_ir_q, prod_ir_d;
    logic signed [15:0]        a_re2_q, a_re2_d, a_im2_q, a_im2_d;
    logic signed [15:0]        bw_re_q, bw_re_d, bw_im_q, bw_im_d;
    logic                      out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic signed [15:0]        x_re_q, x_re_d, x_im_q, x_im_d;
    logic signed [15:0]        y_re_q, y_re_d, y_im_q, y_im_d;

    logic signed [32:0]        w_p_re, w_p_im;
    logic [16:0]               w_sat_re, w_sat_im;
    logic                      w_clip2, w_clip3;
    logic signed [16:0]        w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic signed [15:0]        w_x_re, w_x_im, w_y_re, w_y_im;
`ifndef FFT_BFLY_SCALE_EN
    logic [16:0]               w_sx_re, w_sx_im, w_sy_re, w_sy_im;
`endif

    always_comb begin
        // Stage 1: full-precision partial products
        v1_d      = in_valid;
        a_re1_d   = a_re;
        a_im1_d   = a_im;
        prod_rr_d = 32'(b_re) * 32'(w_re);
        prod_ii_d = 32'(b_im) * 32'(w_im);
        prod_ri_d = 32'(b_re) * 32'(w_im);
        prod_ir_d = 32'(b_im) * 32'(w_re);

        // Stage 2: combine, round half toward +inf, drop the Q1.14 scale
        w_p_re   = 33'(prod_rr_q) - 33'(prod_ii_q);
        w_p_im   = 33'(prod_ri_q) + 33'(prod_ir_q);
        w_sat_re = sat16(19'((w_p_re + c_ROUND) >>> 14));
        w_sat_im = sat16(19'((w_p_im + c_ROUND) >>> 14));
        w_clip2  = w_sat_re[16] | w_sat_im[16];
        v2_d     = v1_q;
        a_re2_d  = a_re1_q;
        a_im2_d  = a_im1_q;
        bw_re_d  = w_sat_re[15:0];
        bw_im_d  = w_sat_im[15:0];

        // Stage 3: sum/difference in 17 bits, then back to 16
        w_sum_re = 17'(a_re2_q) + 17'(bw_re_q);
        w_sum_im = 17'(a_im2_q) + 17'(bw_im_q);
        w_dif_re = 17'(a_re2_q) - 17'(bw_re_q);
        w_dif_im = 17'(a_im2_q) - 17'(bw_im_q);
`ifdef FFT_BFLY_SCALE_EN
        w_x_re  = 16'(w_sum_re >>> 1);
        w_x_im  = 16'(w_sum_im >>> 1);
        w_y_re  = 16'(w_dif_re >>> 1);
        w_y_im  = 16'(w_dif_im >>> 1);
        w_clip3 = 1'b0;
`else
        w_sx_re = sat16(19'(w_sum_re));
        w_sx_im = sat16(19'(w_sum_im));
        w_sy_re = sat16(19'(w_dif_re));
        w_sy_im = sat16(19'(w_dif_im));
        w_x_re  = w_sx_re[15:0];
        w_x_im  = w_sx_im[15:0];
        w_y_re  = w_sy_re[15:0];
        w_y_im  = w_sy_im[15:0];
        w_clip3 = w_sx_re[16] | w_sx_im[16] | w_sy_re[16] | w_sy_im[16];
`endif

        out_valid_d = v2_q;
        x_re_d      = v2_q ? w_x_re : x_re_q;
        x_im_d      = v2_q ? w_x_im : x_im_q;
        y_re_d      = v2_q ? w_y_re : y_re_q;
        y_im_d      = v2_q ? w_y_im : y_im_q;

        // A new saturation outranks a simultaneous clear
        if ((v1_q & w_clip2) | (v2_q & w_clip3))
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            a_re1_q     <= '0;
            a_im1_q     <= '0;
            prod_rr_q   <= '0;
            prod_ii_q   <= '0;
            prod_ri_q   <= '0;
            prod_ir_q   <= '0;
            v2_q        <= 1'b0;
            a_re2_q     <= '0;
            a_im2_q     <= '0;
            bw_re_q     <= '0;
            bw_im_q     <= '0;
            out_valid_q <= 1'b0;
            x_re_q      <= '0;
            x_im_q      <= '0;
            y_re_q      <= '0;
            y_im_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            a_re1_q     <= a_re1_d;
            a_im1_q     <= a_im1_d;
            prod_rr_q   <= prod_rr_d;
            prod_ii_q   <= prod_ii_d;
            prod_ri_q   <= prod_ri_d;
            prod_ir_q   <= prod_ir_d;
            v2_q        <= v2_d;
            a_re2_q     <= a_re2_d;
            a_im2_q     <= a_im2_d;
            bw_re_q     <= bw_re_d;
            bw_im_q     <= bw_im_d;
            out_valid_q <= out_valid_d;
            x_re_q      <= x_re_d;
            x_im_q      <= x_im_d;
            y_re_q      <= y_re_d;
            y_im_q      <= y_im_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign x_re      = x_re_q;
    assign x_im      = x_im_q;
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_butterfly_pipe.sv
`default_nettype none
// =============================================================================
// Module   : tb_fft_butterfly_pipe
// Brief    : Directed and random stimulus for fft_butterfly_pipe against an
//            arithmetic reference model (honours FFT_BFLY_SCALE_EN).
// Revision : 1.0  initial release
// =============================================================================
module tb_fft_butterfly_pipe;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, clr_ovf;
    logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic               out_valid, ovf;
    logic signed [15:0] x_re, x_im, y_re, y_im;

    always #5 clk = ~clk;

    fft_butterfly_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .w_re(w_re), .w_im(w_im), .clr_ovf(clr_ovf),
        .out_valid(out_valid), .x_re(x_re), .x_im(x_im),
        .y_re(y_re), .y_im(y_im), .ovf(ovf)
    );

    typedef struct {
        bit                 v;
        bit                 c2;
        bit                 c3;
        logic signed [15:0] xr, xi, yr, yi;
    } res_t;

    res_t               pipe[$];
    bit                 m_v, m_ovf;
    logic signed [15:0] m_xr, m_xi, m_yr, m_yi;
    int                 checks = 0;
    int                 errors = 0;

    function automatic longint clamp(input longint v, output bit clip);
        clip = (v > 32767) || (v < -32768);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic signed [15:0] fin(input longint s, output bit clip);
`ifdef FFT_BFLY_SCALE_EN
        clip = 1'b0;
        return 16'(longint'($floor(s / 2.0)));
`else
        return 16'(clamp(s, clip));
`endif
    endfunction

    // x = A + round(B*W / 2^14), y = A - round(B*W / 2^14), in plain integers
    function automatic res_t ref_bfly(input bit v, input longint ar, ai, br, bi, wr, wi);
        res_t   r;
        bit     k1, k2, k3, k4, k5, k6;
        longint bwr, bwi;
        bwr  = clamp(longint'($floor((br * wr - bi * wi + 8192.0) / 16384.0)), k1);
        bwi  = clamp(longint'($floor((br * wi + bi * wr + 8192.0) / 16384.0)), k2);
        r.v  = v;
        r.c2 = k1 | k2;
        r.xr = fin(ar + bwr, k3);
        r.xi = fin(ai + bwi, k4);
        r.yr = fin(ar - bwr, k5);
        r.yi = fin(ai - bwi, k6);
        r.c3 = k3 | k4 | k5 | k6;
        return r;
    endfunction

    task automatic model_reset();
        res_t b;
        b = '{default: 0};
        pipe.delete();
        repeat (3) pipe.push_back(b);
        m_v = 0; m_ovf = 0;
        m_xr = 0; m_xi = 0; m_yr = 0; m_yi = 0;
    endtask

    task automatic chk(input string tag, input logic signed [15:0] obs, input logic signed [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 16'(out_valid), 16'(m_v));
        chk("x_re", x_re, m_xr);
        chk("x_im", x_im, m_xi);
        chk("y_re", y_re, m_yr);
        chk("y_im", y_im, m_yi);
        chk("ovf", 16'(ovf), 16'(m_ovf));
    endtask

    // One clock edge: advance the model with the inputs present at the edge
    task automatic tick();
        res_t r;
        bit   set;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            r = ref_bfly(in_valid, a_re, a_im, b_re, b_im, w_re, w_im);
            pipe.push_back(r);
            void'(pipe.pop_front());
            set = (pipe[1].v && pipe[1].c2) || (pipe[0].v && pipe[0].c3);
            if (set)          m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            m_v = pipe[0].v;
            if (m_v) begin
                m_xr = pipe[0].xr; m_xi = pipe[0].xi;
                m_yr = pipe[0].yr; m_yi = pipe[0].yi;
            end
        end
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input int ar, ai, br, bi, wr, wi, input bit clr);
        in_valid = v; clr_ovf = clr;
        a_re = 16'(ar); a_im = 16'(ai);
        b_re = 16'(br); b_im = 16'(bi);
        w_re = 16'(wr); w_im = 16'(wi);
        tick();
    endtask

    task automatic drive_rand(input bit v, input bit clr);
        int wmax;
        wmax = ($urandom_range(0, 1) == 0) ? 16384 : 32767;
        drive(v, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 2 * wmax)) - wmax, int'($urandom_range(0, 2 * wmax)) - wmax, clr);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit pat[8];
        pat = '{1, 0, 1, 1, 0, 1, 1, 1};
        in_valid = 0; clr_ovf = 0;
        a_re = 0; a_im = 0; b_re = 0; b_im = 0; w_re = 0; w_im = 0;
        rst = 0;
        #1 rst = 1;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;

        // Identity twiddle
        drive(1, 1000, 0, 500, 0, 16384, 0, 0);
        idle(3);
        // W = -j
        drive(1, 0, 0, 100, 200, 0, -16384, 0);
        idle(3);
        // Rounding half toward +inf, positive and negative
        drive(1, 0, 0, 3, 0, 8192, 0, 0);
        drive(1, 0, 0, -3, 0, 8192, 0, 0);
        idle(3);
        // Stage-3 clip: flag is sticky until cleared
        drive(1, 30000, 0, 10000, 0, 16384, 0, 0);
        idle(5);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // Stage-2 clip, then a clear on the same edge as the clip
        drive(1, 0, 0, -32768, -32768, 16384, -16384, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Valid pattern with bubbles
        for (int i = 0; i < 8; i++) drive_rand(pat[i], 0);
        idle(4);

        // Random stream with sporadic clears
        for (int i = 0; i < 200; i++)
            drive_rand($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
        idle(4);

        // Reset with operand sets in flight
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 30000, 0, 10000, 0, 16384, 0, 0);
        drive(1, 0, 0, -32768, -32768, 16384, -16384, 0);
        drive_rand(1, 0);
        drive_rand(1, 0);
        in_valid = 1;
        #3 rst = 1;
        #1;
        model_reset();
        check_all();
        tick();
        rst = 0;
        idle(4);
        drive(1, 1000, 0, 500, 0, 16384, 0, 0);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
